// File: rtl/score_argmax_seq.sv
// Sequential argmax over NUM_CLASSES signed scores, one compare per clock, reporting index, score and runner-up margin.
// Optional low-confidence flag is compiled in when SCORE_CONF_CHECK_EN is defined.
module score_argmax_seq #(
  parameter int        NUM_CLASSES = 10,
  parameter int        SCORE_W     = 16,
  parameter int        IDX_W       = $clog2(NUM_CLASSES),
  parameter int signed CONF_THRESH = 16'sd64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [NUM_CLASSES*SCORE_W-1:0] in_scores,
  output logic                           in_ready,
  output logic                           pred_valid,
  output logic [IDX_W-1:0]               pred_idx,
  output logic [SCORE_W-1:0]             pred_score,
  output logic [SCORE_W:0]               pred_margin,
  output logic                           drop_err,
  output logic                           low_conf
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [SCORE_W-1:0] w_score  [NUM_CLASSES];
  logic signed [SCORE_W-1:0] r_shadow [NUM_CLASSES];
  logic signed [SCORE_W-1:0] r_best;
  logic signed [SCORE_W-1:0] r_second;
  logic [IDX_W-1:0]          r_best_idx;
  logic [IDX_W-1:0]          r_cnt;

  logic                      r_pred_valid;
  logic [IDX_W-1:0]          r_pred_idx;
  logic [SCORE_W-1:0]        r_pred_score;
  logic [SCORE_W:0]          r_pred_margin;
  logic                      r_drop_err;

  logic signed [SCORE_W-1:0] w_s;
  logic                      w_last;
  logic                      w_accept;
  logic [SCORE_W:0]          w_margin;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_lane
      assign w_score[gi] = in_scores[gi*SCORE_W +: SCORE_W];

      // Shadow copy isolates the scan from later changes on the input bus.
      always_ff @(posedge clk) begin
        if (w_accept) begin
          r_shadow[gi] <= w_score[gi];
        end
      end
    end
  endgenerate

  assign in_ready = (r_state == ST_IDLE);
  assign w_accept = in_ready && in_valid && !rst;
  assign w_s      = r_shadow[r_cnt];
  assign w_last   = (r_cnt == IDX_W'(NUM_CLASSES - 1));
  // best >= second always holds, so the extended difference is non-negative.
  assign w_margin = {r_best[SCORE_W-1], r_best} - {r_second[SCORE_W-1], r_second};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_next = ST_SCAN;
      ST_SCAN: if (w_last)   w_state_next = ST_DONE;
      ST_DONE:               w_state_next = ST_IDLE;
      default:               w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_best        <= '0;
      r_second      <= '0;
      r_best_idx    <= '0;
      r_cnt         <= '0;
      r_pred_valid  <= 1'b0;
      r_pred_idx    <= '0;
      r_pred_score  <= '0;
      r_pred_margin <= '0;
      r_drop_err    <= 1'b0;
    end else begin
      r_pred_valid <= 1'b0;
      if (in_valid && !in_ready) begin
        r_drop_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_best     <= w_score[0];
            r_best_idx <= '0;
            r_second   <= {1'b1, {(SCORE_W-1){1'b0}}};
            r_cnt      <= IDX_W'(1);
          end
        end
        ST_SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (w_s > r_best) begin
            r_second   <= r_best;
            r_best     <= w_s;
            r_best_idx <= r_cnt;
          end else if (w_s > r_second) begin
            r_second <= w_s;
          end
          if (!w_last) begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end
        ST_DONE: begin
          r_pred_valid  <= 1'b1;
          r_pred_idx    <= r_best_idx;
          r_pred_score  <= r_best;
          r_pred_margin <= w_margin;
        end
        default: ;
      endcase
    end
  end

  assign pred_valid  = r_pred_valid;
  assign pred_idx    = r_pred_idx;
  assign pred_score  = r_pred_score;
  assign pred_margin = r_pred_margin;
  assign drop_err    = r_drop_err;

`ifdef SCORE_CONF_CHECK_EN
  localparam logic signed [SCORE_W+1:0] THRESH_EXT = (SCORE_W+2)'(CONF_THRESH);
  logic r_low_conf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_low_conf <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_low_conf <= ($signed({1'b0, w_margin}) < THRESH_EXT);
    end
  end

  assign low_conf = r_low_conf;
`else
  assign low_conf = 1'b0;
`endif

endmodule

// File: doc/score_argmax_seq.md
Name: score_argmax_seq

Overview:
- Parametrised, sequential classifier output stage; successor to the fixed 10-class inline argmax at the end of the inference pipeline.
- Accepts a flat bus of NUM_CLASSES signed scores (from the softmax or the last layer) with a valid strobe.
- Scans one score per cycle and reports winning index, winning score, runner-up margin and a one-cycle result-valid pulse.
- Uses a ready/busy handshake so back-to-back inferences cannot corrupt a scan in progress.

Parameters:
- NUM_CLASSES, 10, number of scores on the input bus (must be >= 2).
- SCORE_W, 16, bit width of each signed two's-complement score.
- IDX_W, $clog2(NUM_CLASSES), width of the index output.
- CONF_THRESH, 16'sd64, minimum margin for a confident result (used only with SCORE_CONF_CHECK_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  scores on in_scores valid this cycle.
- in_scores  in  NUM_CLASSES*SCORE_W  flat score bus; class k at bits [k*SCORE_W +: SCORE_W].
- in_ready  out  1  high when IDLE (combinational from state); in_valid sampled only when in_ready=1.
- pred_valid  out  1  one-cycle pulse; result outputs updated on the same edge.
- pred_idx  out  IDX_W  index of the maximum score.
- pred_score  out  SCORE_W  maximum score value (signed).
- pred_margin  out  SCORE_W+1  unsigned best minus runner-up.
- drop_err  out  1  sticky; set when in_valid=1 while in_ready=0.
- low_conf  out  1  pred_margin < CONF_THRESH (only with SCORE_CONF_CHECK_EN, else tied 0).

Behaviour:
- Reset (synchronous): state=IDLE; pred_valid=0, pred_idx=0, pred_score=0, pred_margin=0, drop_err=0, low_conf=0; in_ready=1 the cycle after reset.
- Reset mid-scan: aborts the scan, discards working registers, no pred_valid.
- States: IDLE, SCAN, DONE.
- IDLE:
  - On in_valid at edge E0, latch in_scores into a shadow register.
  - Initialise best=score[0], best_idx=0, second=most-negative (1 followed by zeros), cnt=1.
  - Go to SCAN.
- SCAN, one compare per edge on s=shadow[cnt]:
  - If s > best (signed, strict): second<=best, best<=s, best_idx<=cnt.
  - Else if s > second: second<=s.
  - At cnt==NUM_CLASSES-1, after the compare, go to DONE; otherwise cnt<=cnt+1.
  - Compares occupy edges E1..E(NUM_CLASSES-1).
- DONE, at edge E(NUM_CLASSES):
  - pred_idx<=best_idx, pred_score<=best, pred_margin<=best-second computed in SCORE_W+1 bits.
  - pred_valid<=1 for exactly one cycle; state<=IDLE.
  - Latency: pred_valid high exactly NUM_CLASSES cycles after the cycle in_valid was accepted.
  - Next input can be accepted at E(NUM_CLASSES+1).
- Ties: the lowest index wins. Equal scores leave second=best, so margin=0.
- Result outputs hold their values between pulses.
- in_scores changing during SCAN has no effect (shadow copy).
- in_valid while not ready: input ignored, drop_err<=1 and stays set until rst.
- in_valid and rst in the same cycle: reset wins.

Optional Feature:
- Macro SCORE_CONF_CHECK_EN.
- Defined: low_conf is registered on the DONE edge as (pred_margin < CONF_THRESH) and holds with the other results.
- Undefined: low_conf is constant 0 and no comparator is synthesised.

Test Plan:
- Scores {5,-3,12,7,0,1,2,3,4,11}, in_valid 1 cycle -> pred_valid exactly 10 cycles later; pred_idx=2, pred_score=12, pred_margin=1.
- All scores equal to -100 -> pred_idx=0, pred_score=-100, pred_margin=0; with SCORE_CONF_CHECK_EN, low_conf=1.
- Scores {-32768 x9, 32767 at idx 9} -> pred_idx=9, pred_margin=65535 (17-bit, no overflow).
- in_valid pulsed again 3 cycles after acceptance -> drop_err=1 (sticky), first result unaffected, no second pred_valid.
- rst asserted 4 cycles into a scan -> no pred_valid; all outputs 0; in_ready=1 next cycle; new input then gives a correct result.
- NUM_CLASSES=4, SCORE_W=8, scores {3,9,9,-1} -> pred_idx=1, pred_margin=0, latency 4 cycles.
